alu_ctl_exec: RTL and testbench
===============================

Name: alu_ctl_exec

Overview:
- RV32I execute-stage block: decodes {instr[30], funct3} and the 7-bit opcode into an internal 7-bit ALU control code, then performs the selected 32-bit operation on operands a and b.
- Produces a result word and a branch-taken flag.
- Sits between the decode/register-read stage and writeback/PC-select.
- Decode and ALU are combinational; all outputs are registered.

Parameters:
- WIDTH, 32, operand/result width (only 32 is supported).

Ports:
- clk  in  1  system clock; all registers update on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- func_code  in  4  {instr[30], instr[14:12]}.
- opcode  in  7  instr[6:0].
- a  in  32  operand A (rs1 or PC).
- b  in  32  operand B (rs2 or immediate).
- alu_ctl  out  7  registered decoded control code.
- alu_out  out  32  registered result.
- branch_enable  out  1  registered branch-taken flag.

Behaviour:
- Reset: while rst_n=0, alu_ctl=7'h7F, alu_out=0, branch_enable=0. Reset asserts immediately (asynchronously); release is taken at the next clk edge.
- Latency: inputs are sampled on a clk rising edge and the results are visible after that edge (1 cycle). No handshake; the block accepts new inputs every cycle.
- Control codes:
  - 00 AND, 01 OR, 02 ADD, 03 SUB, 04 SLT, 05 SLTU, 06 SLL, 07 SRL, 08 SRA, 09 XOR, 0A PASSB.
  - Branch codes are 7'h40|funct3: 40 BEQ, 41 BNE, 44 BLT, 45 BGE, 46 BLTU, 47 BGEU.
  - 7F NOP.
- Opcode 0110011 (R-type), decoded by funct3:
  - 000: ADD, or SUB if func_code[3]=1.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA if func_code[3]=1.
  - 110: OR.
  - 111: AND.
- Opcode 0010011 (I-type ALU): same decode as R-type, except func_code[3] is ignored for funct3=000 (always ADD). func_code[3] is honoured for 101 (SRAI/SRLI).
- Opcodes 0000011 (load), 0100011 (store), 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR): ADD.
- Opcode 0110111 (LUI): PASSB.
- Opcode 1100011 (branch): branch code from funct3. Undefined funct3 (010, 011) gives NOP.
- Any other opcode (including 0000000): NOP.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^32; no carry/overflow output.
  - SLT is a signed compare; SLTU is unsigned. Both give result 1 or 0.
  - Shift amount is b[4:0]; b[31:5] are ignored.
  - SRA replicates a[31].
  - PASSB gives alu_out=b.
- Branch codes:
  - alu_out=0.
  - branch_enable = (a==b) for BEQ, (a!=b) for BNE, signed a<b for BLT, signed a>=b for BGE, unsigned a<b for BLTU, unsigned a>=b for BGEU.
- branch_enable=0 for every non-branch code.
- NOP gives alu_out=0 and branch_enable=0.
- No internal state beyond the output registers. An inputs change mid-cycle has no effect until the next edge. Reset mid-operation discards the pending result.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> alu_out=0, branch_enable=0, alu_ctl=7F. Deassert with opcode=0 -> outputs stay 0 / 7F.
- R-type logic, one vector per cycle, with opcode=0110011, a=0x0F, b=0x55:
  - func 0111 -> alu_out=0x05.
  - func 0110 -> 0x5F.
  - a=0x55, b=0xFF, func 0100 -> 0xAA.
  - Each result appears one cycle after its inputs are applied.
- R-type arithmetic, with opcode=0110011, a=10000, b=111:
  - func 0000 -> 10111.
  - func 1000 -> 9889.
  - a=0, b=2, func 0010 -> 1.
  - a=0xFFFFFFFF, b=1: SLT -> 1; SLTU (func 0011) -> 0.
- Shifts, with opcode=0110011:
  - a=16, b=2, func 0101 -> 4.
  - a=8, b=1, func 1101 -> 4.
  - a=0x80000000, b=4, func 1101 -> 0xF8000000.
  - a=2, b=2, func 0001 -> 8.
  - b=0x22 shifts by 2.
- I-type and misc:
  - opcode 0010011, func 1000, a=5, b=3 -> 8 (ADDI, not SUB).
  - LUI with b=0x12345000 -> 0x12345000.
  - JALR a=0x100, b=4 -> 0x104.
  - Undefined opcode 1111111 -> alu_out=0.
- Branches, with opcode=1100011:
  - a=b=7: func 0000 -> branch_enable=1; func 0001 -> 0.
  - a=0xFFFFFFFF, b=1: BLT -> 1; BLTU -> 0; BGEU -> 1.
  - alu_out=0 in all branch cases.
  - Async reset asserted mid-vector -> outputs clear without waiting for clk.

Source files
------------

// File: rtl/alu_ctl_exec.sv
// RV32I execute stage: decodes {instr[30], funct3} and the opcode into a 7-bit ALU
// control code, runs the 32-bit operation, and registers control, result and branch flag.
module alu_ctl_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       func_code,
  input  logic [6:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [6:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_out,
  output logic             branch_enable
);

  localparam logic [6:0] C_AND   = 7'h00;
  localparam logic [6:0] C_OR    = 7'h01;
  localparam logic [6:0] C_ADD   = 7'h02;
  localparam logic [6:0] C_SUB   = 7'h03;
  localparam logic [6:0] C_SLT   = 7'h04;
  localparam logic [6:0] C_SLTU  = 7'h05;
  localparam logic [6:0] C_SLL   = 7'h06;
  localparam logic [6:0] C_SRL   = 7'h07;
  localparam logic [6:0] C_SRA   = 7'h08;
  localparam logic [6:0] C_XOR   = 7'h09;
  localparam logic [6:0] C_PASSB = 7'h0A;
  localparam logic [6:0] C_BEQ   = 7'h40;
  localparam logic [6:0] C_BNE   = 7'h41;
  localparam logic [6:0] C_BLT   = 7'h44;
  localparam logic [6:0] C_BGE   = 7'h45;
  localparam logic [6:0] C_BLTU  = 7'h46;
  localparam logic [6:0] C_BGEU  = 7'h47;
  localparam logic [6:0] C_NOP   = 7'h7F;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [6:0]       ctl;
    logic [WIDTH-1:0] res;
    logic             br;
  } exec_rsp_t;

  logic [2:0]  funct3;
  logic        alt;
  logic [6:0]  ctl;
  logic [4:0]  shamt;
  logic        lt_s, lt_u, eq;
  exec_rsp_t   rsp_d, rsp_q;

  assign funct3 = func_code[2:0];
  assign alt    = func_code[3];
  assign shamt  = b[4:0];
  assign eq     = (a == b);
  assign lt_s   = ($signed(a) < $signed(b));
  assign lt_u   = (a < b);

  // I-type shares the R-type table except that bit 30 is immediate data for ADDI.
  always_comb begin
    ctl = C_NOP;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          3'b000: ctl = (alt && opcode == OP_R) ? C_SUB : C_ADD;
          3'b001: ctl = C_SLL;
          3'b010: ctl = C_SLT;
          3'b011: ctl = C_SLTU;
          3'b100: ctl = C_XOR;
          3'b101: ctl = alt ? C_SRA : C_SRL;
          3'b110: ctl = C_OR;
          default: ctl = C_AND;
        endcase
      end
      OP_LOAD, OP_STORE, OP_AUIPC, OP_JAL, OP_JALR: ctl = C_ADD;
      OP_LUI: ctl = C_PASSB;
      OP_BRANCH: begin
        case (funct3)
          3'b010, 3'b011: ctl = C_NOP;
          default:        ctl = {4'b1000, funct3};
        endcase
      end
      default: ctl = C_NOP;
    endcase
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.ctl = ctl;
    case (ctl)
      C_AND:   rsp_d.res = a & b;
      C_OR:    rsp_d.res = a | b;
      C_ADD:   rsp_d.res = a + b;
      C_SUB:   rsp_d.res = a - b;
      C_SLT:   rsp_d.res = {{(WIDTH-1){1'b0}}, lt_s};
      C_SLTU:  rsp_d.res = {{(WIDTH-1){1'b0}}, lt_u};
      C_SLL:   rsp_d.res = a << shamt;
      C_SRL:   rsp_d.res = a >> shamt;
      C_SRA:   rsp_d.res = $unsigned($signed(a) >>> shamt);
      C_XOR:   rsp_d.res = a ^ b;
      C_PASSB: rsp_d.res = b;
      C_BEQ:   rsp_d.br  = eq;
      C_BNE:   rsp_d.br  = ~eq;
      C_BLT:   rsp_d.br  = lt_s;
      C_BGE:   rsp_d.br  = ~lt_s;
      C_BLTU:  rsp_d.br  = lt_u;
      C_BGEU:  rsp_d.br  = ~lt_u;
      default: rsp_d.res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q.ctl <= C_NOP;
      rsp_q.res <= '0;
      rsp_q.br  <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign alu_ctl       = rsp_q.ctl;
  assign alu_out       = rsp_q.res;
  assign branch_enable = rsp_q.br;

endmodule

// File: tb/tb_alu_ctl_exec.sv
// Scoreboard bench for alu_ctl_exec: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares against the registered outputs.
module tb_alu_ctl_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  func_code;
  logic [6:0]  opcode;
  logic [31:0] a, b;
  logic [6:0]  alu_ctl;
  logic [31:0] alu_out;
  logic        branch_enable;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [31:0] res;
    logic        br;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;

  alu_ctl_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .func_code(func_code), .opcode(opcode),
    .a(a), .b(b), .alu_ctl(alu_ctl), .alu_out(alu_out), .branch_enable(branch_enable)
  );

  always #5 clk = ~clk;

  // Outputs seen at a negedge reflect the inputs sampled at the preceding posedge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      if (alu_ctl !== e.ctl || alu_out !== e.res || branch_enable !== e.br) begin
        bad++;
        $display("FAIL %s: got ctl=%02h out=%08h br=%0b, want ctl=%02h out=%08h br=%0b",
                 e.name, alu_ctl, alu_out, branch_enable, e.ctl, e.res, e.br);
      end
    end
  end

  task automatic apply(input string nm, input logic [3:0] f, input logic [6:0] op,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [6:0] ec, input logic [31:0] er, input logic eb);
    exp_t e;
    @(negedge clk);
    #1;
    func_code = f; opcode = op; a = av; b = bv;
    e.name = nm; e.ctl = ec; e.res = er; e.br = eb;
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string nm, input logic [6:0] ec, input logic [31:0] er,
                           input logic eb);
    total++;
    if (alu_ctl !== ec || alu_out !== er || branch_enable !== eb) begin
      bad++;
      $display("FAIL %s: got ctl=%02h out=%08h br=%0b, want ctl=%02h out=%08h br=%0b",
               nm, alu_ctl, alu_out, branch_enable, ec, er, eb);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    func_code = 4'h0; opcode = R; a = 32'h1234; b = 32'h1;
    // Reset held with live ADD inputs: outputs stay at reset values.
    apply("reset_hold0", 4'h0, R,  32'h1234, 32'h1, 7'h7F, 32'h0, 1'b0);
    apply("reset_hold1", 4'h0, BR, 32'h7, 32'h7, 7'h7F, 32'h0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    apply("release_nop", 4'h0, 7'h00, 32'h5, 32'h3, 7'h7F, 32'h0, 1'b0);

    apply("r_and",   4'b0111, R, 32'h0F, 32'h55, 7'h00, 32'h05, 1'b0);
    apply("r_or",    4'b0110, R, 32'h0F, 32'h55, 7'h01, 32'h5F, 1'b0);
    apply("r_xor",   4'b0100, R, 32'h55, 32'hFF, 7'h09, 32'hAA, 1'b0);
    apply("r_add",   4'b0000, R, 32'd10000, 32'd111, 7'h02, 32'd10111, 1'b0);
    apply("r_sub",   4'b1000, R, 32'd10000, 32'd111, 7'h03, 32'd9889, 1'b0);
    apply("r_add_wrap", 4'b0000, R, 32'hFFFFFFFF, 32'h1, 7'h02, 32'h0, 1'b0);
    apply("r_slt_pos", 4'b0010, R, 32'h0, 32'h2, 7'h04, 32'h1, 1'b0);
    apply("r_slt_neg", 4'b0010, R, 32'hFFFFFFFF, 32'h1, 7'h04, 32'h1, 1'b0);
    apply("r_sltu",  4'b0011, R, 32'hFFFFFFFF, 32'h1, 7'h05, 32'h0, 1'b0);
    apply("r_srl",   4'b0101, R, 32'd16, 32'd2, 7'h07, 32'd4, 1'b0);
    apply("r_sra_pos", 4'b1101, R, 32'd8, 32'd1, 7'h08, 32'd4, 1'b0);
    apply("r_sra_neg", 4'b1101, R, 32'h80000000, 32'd4, 7'h08, 32'hF8000000, 1'b0);
    apply("r_srl_neg", 4'b0101, R, 32'h80000000, 32'd4, 7'h07, 32'h08000000, 1'b0);
    apply("r_sll",   4'b0001, R, 32'd2, 32'd2, 7'h06, 32'd8, 1'b0);
    apply("r_sll_b22", 4'b0001, R, 32'd2, 32'h22, 7'h06, 32'd8, 1'b0);

    apply("i_addi_bit30", 4'b1000, I, 32'd5, 32'd3, 7'h02, 32'd8, 1'b0);
    apply("i_srai",  4'b1101, I, 32'h80000000, 32'd4, 7'h08, 32'hF8000000, 1'b0);
    apply("lui",     4'b0101, 7'b0110111, 32'hDEAD, 32'h12345000, 7'h0A, 32'h12345000, 1'b0);
    apply("jalr",    4'b1000, 7'b1100111, 32'h100, 32'h4, 7'h02, 32'h104, 1'b0);
    apply("load",    4'b0010, 7'b0000011, 32'h1000, 32'hFFFFFFFC, 7'h02, 32'hFFC, 1'b0);
    apply("undef_op", 4'b0000, 7'b1111111, 32'd5, 32'd3, 7'h7F, 32'h0, 1'b0);

    apply("beq",  4'b0000, BR, 32'd7, 32'd7, 7'h40, 32'h0, 1'b1);
    apply("bne",  4'b0001, BR, 32'd7, 32'd7, 7'h41, 32'h0, 1'b0);
    apply("blt",  4'b0100, BR, 32'hFFFFFFFF, 32'h1, 7'h44, 32'h0, 1'b1);
    apply("bge",  4'b0101, BR, 32'hFFFFFFFF, 32'h1, 7'h45, 32'h0, 1'b0);
    apply("bltu", 4'b0110, BR, 32'hFFFFFFFF, 32'h1, 7'h46, 32'h0, 1'b0);
    apply("bgeu", 4'b0111, BR, 32'hFFFFFFFF, 32'h1, 7'h47, 32'h0, 1'b1);
    apply("br_undef", 4'b0010, BR, 32'd7, 32'd7, 7'h7F, 32'h0, 1'b0);
    apply("pre_rst_add", 4'b0000, R, 32'd1, 32'd2, 7'h02, 32'd3, 1'b0);

    // Let the monitor consume the last vector, then reset asynchronously mid-cycle.
    @(negedge clk);
    #2;
    func_code = 4'b0110; opcode = R; a = 32'hF0; b = 32'h0F;
    #1;
    check_now("pre_async_hold", 7'h02, 32'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 7'h7F, 32'h0, 1'b0);
    @(posedge clk); #1;
    check_now("reset_after_edge", 7'h7F, 32'h0, 1'b0);
    rst_n = 1'b1;
    apply("post_rst_or", 4'b0110, R, 32'hF0, 32'h0F, 7'h01, 32'hFF, 1'b0);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
